// File: rtl/text_pkg.sv
// Shared constants, state encoding and address helpers for the text console.
// Geometry is fixed at 80x30 cells of 8x16 pixels, stored as a 2400-byte buffer.
// Helpers use compare-and-subtract and shift-add only, with no dividers or multipliers.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int CELLS  = COLS * ROWS;
  localparam int AW     = 12;

  localparam logic [7:0] CLR_BYTE = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_t;

  // Reduce a sum of two row indices (each below ROWS) back into 0..ROWS-1.
  function automatic logic [4:0] row_wrap(input logic [5:0] sum);
    if (sum >= 6'(ROWS))
      return 5'(sum - 6'(ROWS));
    return sum[4:0];
  endfunction

  // Linear cell address: prow*80 + col, built as prow*64 + prow*16 + col.
  function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return {1'b0, prow, 6'b0} + {3'b0, prow, 4'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/text_ram.sv
// Character buffer: simple dual-port RAM with one write port and one registered read port.
// Read latency 1 cycle; a same-cycle read of the cell being written returns the old byte.
// No backpressure; both ports operate every cycle.
module text_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          iClk_50,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Read and write in one block so the read samples the pre-write contents.
  always_ff @(posedge iClk_50) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console.sv
// Console writer and character-cell buffer feeding the font ROM from VGA pixel coordinates.
// Read path latency 1 cycle; accepted bytes are written and move the cursor at the accepting edge.
// oReady is low while clearing a line (80 cycles) or the whole screen (2400 cycles).
module text_console
  import text_pkg::*;
(
  input  logic       iClk_50,
  input  logic       Rst,
  input  logic [7:0] iChar,
  input  logic       iValid,
  output logic       oReady,
  input  logic [9:0] iRow,
  input  logic [9:0] iCol,
  output logic [7:0] oChar,
  output logic [4:0] oCurRow,
  output logic [6:0] oCurCol
);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic [4:0]    top, top_nxt;
  logic [4:0]    cur_row, cur_row_nxt;
  logic [6:0]    cur_col, cur_col_nxt;
  logic [4:0]    clr_row, clr_row_nxt;
  logic          do_newline;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_dat;
  logic [4:0]    wr_prow;

  logic          rd_in_range;
  logic          rd_vld_q;
  logic [4:0]    rd_prow;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_dat;

  // Cursor row is logical; the buffer row it lands on rotates with top.
  assign wr_prow = row_wrap({1'b0, cur_row} + {1'b0, top});

  // Pixel to cell: line = iRow/16, column = iCol/8, line rotated by top.
  assign rd_in_range = (iRow < 10'(ROWS * CHAR_H)) && (iCol < 10'(COLS * CHAR_W));
  assign rd_prow     = row_wrap({1'b0, iRow[8:4]} + {1'b0, top});
  assign rd_addr     = rd_in_range ? cell_addr(rd_prow, iCol[9:3]) : '0;

  text_ram #(
    .DEPTH(CELLS),
    .AW   (AW),
    .DW   (8)
  ) u_ram (
    .iClk_50(iClk_50),
    .we     (wr_en & ~Rst),
    .waddr  (wr_addr),
    .wdata  (wr_dat),
    .raddr  (rd_addr),
    .rdata  (rd_dat)
  );

  // FSM and cursor/top registers; reset always restarts the full clear from cell 0.
  always_ff @(posedge iClk_50) begin
    if (Rst) begin
      state   <= CLR_ALL;
      clr_cnt <= '0;
      top     <= '0;
      cur_row <= '0;
      cur_col <= '0;
      clr_row <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      top     <= top_nxt;
      cur_row <= cur_row_nxt;
      cur_col <= cur_col_nxt;
      clr_row <= clr_row_nxt;
    end
  end

  // Remember whether the sampled pixel was on screen so off-screen pixels show 0x00.
  always_ff @(posedge iClk_50) begin
    if (Rst)
      rd_vld_q <= 1'b0;
    else
      rd_vld_q <= rd_in_range;
  end

  assign oChar   = rd_vld_q ? rd_dat : 8'h00;
  assign oCurRow = cur_row;
  assign oCurCol = cur_col;

  // Next-state, byte decode, newline/scroll handling and RAM write port selection.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    top_nxt     = top;
    cur_row_nxt = cur_row;
    cur_col_nxt = cur_col;
    clr_row_nxt = clr_row;
    do_newline  = 1'b0;
    oReady      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = cell_addr(wr_prow, cur_col);
    wr_dat      = CLR_BYTE;

    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          if (iChar >= PRINT_LO && iChar <= PRINT_HI) begin
            wr_en  = 1'b1;
            wr_dat = iChar;
            if (cur_col == 7'(COLS - 1)) begin
              cur_col_nxt = '0;
              do_newline  = 1'b1;
            end else begin
              cur_col_nxt = cur_col + 7'd1;
            end
          end else if (iChar == CH_LF) begin
            cur_col_nxt = '0;
            do_newline  = 1'b1;
          end else if (iChar == CH_CR) begin
            cur_col_nxt = '0;
          end else if (iChar == CH_BS) begin
            if (cur_col != 7'd0)
              cur_col_nxt = cur_col - 7'd1;
          end else if (iChar == CH_FF) begin
            state_nxt   = CLR_ALL;
            clr_cnt_nxt = '0;
          end
          // Newline either moves down or scrolls; scrolling recycles the old top row
          // as the new bottom line, so that physical row is the one to blank.
          if (do_newline) begin
            if (cur_row != 5'(ROWS - 1)) begin
              cur_row_nxt = cur_row + 5'd1;
            end else begin
              top_nxt     = (top == 5'(ROWS - 1)) ? 5'd0 : top + 5'd1;
              clr_row_nxt = top;
              state_nxt   = CLR_LINE;
              clr_cnt_nxt = '0;
            end
          end
        end
      end

      CLR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(clr_row, clr_cnt[6:0]);
        if (clr_cnt == AW'(COLS - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end

      CLR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        if (clr_cnt == AW'(CELLS - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
          top_nxt     = '0;
          cur_row_nxt = '0;
          cur_col_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt   = CLR_ALL;
        clr_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: reset clear, printing, read-before-write,
// control codes, wrap, scroll, wrap-scroll, form feed and reset during a line clear.
module tb_text_console;

  logic       iClk_50 = 1'b0;
  logic       Rst     = 1'b1;
  logic [7:0] iChar   = 8'h00;
  logic       iValid  = 1'b0;
  logic       oReady;
  logic [9:0] iRow    = 10'd0;
  logic [9:0] iCol    = 10'd0;
  logic [7:0] oChar;
  logic [4:0] oCurRow;
  logic [6:0] oCurCol;

  int vectors     = 0;
  int miscompares = 0;

  text_console dut (
    .iClk_50(iClk_50),
    .Rst    (Rst),
    .iChar  (iChar),
    .iValid (iValid),
    .oReady (oReady),
    .iRow   (iRow),
    .iCol   (iCol),
    .oChar  (oChar),
    .oCurRow(oCurRow),
    .oCurCol(oCurCol)
  );

  always #10 iClk_50 = ~iClk_50;

  initial begin
    #20ms;
    $display("FAIL watchdog: observed no finish, expected finish before 20ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge iClk_50);
    iChar  = b;
    iValid = 1'b1;
    while (!oReady && n < 5000) begin
      @(negedge iClk_50);
      n++;
    end
    if (!oReady)
      check("send_timeout", {31'b0, oReady}, 32'd1);
    @(posedge iClk_50);
    #1;
    iValid = 1'b0;
  endtask

  task automatic read_cell(input int line, input int col, output logic [7:0] v);
    @(negedge iClk_50);
    iRow = 10'(line * 16 + line % 16);
    iCol = 10'(col * 8 + col % 8);
    @(posedge iClk_50);
    #1;
    v = oChar;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!oReady && cycles < 5000) begin
      @(posedge iClk_50);
      #1;
      cycles++;
    end
  endtask

  task automatic check_cell(input string tag, input int line, input int col, input logic [7:0] exp);
    logic [7:0] v;
    read_cell(line, col, v);
    check(tag, {24'b0, v}, {24'b0, exp});
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check({tag, "_row"}, {27'b0, oCurRow}, 32'(row));
    check({tag, "_col"}, {25'b0, oCurCol}, 32'(col));
  endtask

  initial begin
    int         c;
    int         bad;
    logic [7:0] v;

    // Reset held: outputs at their reset values.
    repeat (3) @(posedge iClk_50);
    #1;
    check("rst_ready", {31'b0, oReady}, 32'd0);
    check("rst_char", {24'b0, oChar}, 32'h00);
    check_cursor("rst_cursor", 0, 0);

    // Release: 2400 edges of clear before the first byte can be taken.
    @(negedge iClk_50);
    Rst = 1'b0;
    wait_ready(c);
    check("reset_clear_cycles", 32'(c), 32'd2400);

    bad = 0;
    for (int l = 0; l < 30; l++)
      for (int k = 0; k < 80; k++) begin
        read_cell(l, k, v);
        if (v !== 8'h20) bad++;
      end
    check("blank_screen_bad_cells", 32'(bad), 32'd0);

    // Off-screen pixels and the last on-screen pixel.
    @(negedge iClk_50); iRow = 10'd480; iCol = 10'd0;
    @(posedge iClk_50); #1;
    check("offscreen_row480", {24'b0, oChar}, 32'h00);
    @(negedge iClk_50); iRow = 10'd479; iCol = 10'd639;
    @(posedge iClk_50); #1;
    check("last_pixel", {24'b0, oChar}, 32'h20);
    @(negedge iClk_50); iRow = 10'd0; iCol = 10'd640;
    @(posedge iClk_50); #1;
    check("offscreen_col640", {24'b0, oChar}, 32'h00);

    // Print "Hi".
    send(8'h48);
    send(8'h69);
    check_cursor("hi_cursor", 0, 2);
    check_cell("hi_cell1", 0, 1, 8'h69);
    check_cell("hi_cell0", 0, 0, 8'h48);

    // Read and write the same cell in one cycle: old byte first, new byte next.
    @(negedge iClk_50);
    iRow = 10'd0; iCol = 10'd16; iChar = 8'h21; iValid = 1'b1;
    check("rbw_ready", {31'b0, oReady}, 32'd1);
    @(posedge iClk_50); #1;
    iValid = 1'b0;
    check("rbw_old", {24'b0, oChar}, 32'h20);
    @(posedge iClk_50); #1;
    check("rbw_new", {24'b0, oChar}, 32'h21);
    check_cursor("rbw_cursor", 0, 3);

    // Control codes.
    send(8'h08);
    check_cursor("bs_cursor", 0, 2);
    check_cell("bs_no_erase", 0, 2, 8'h21);
    send(8'h07);
    check_cursor("bel_cursor", 0, 2);
    send(8'h0D);
    check_cursor("cr_cursor", 0, 0);
    send(8'h08);
    check_cursor("bs_at_col0", 0, 0);

    // Wrap: 81 'A' from (0,0).
    for (int i = 0; i < 81; i++) send(8'h41);
    check_cursor("wrap_cursor", 1, 1);
    check_cell("wrap_cell_1_0", 1, 0, 8'h41);
    check_cell("wrap_cell_0_79", 0, 79, 8'h41);
    check_cell("wrap_cell_1_1", 1, 1, 8'h20);

    // Move to (29,5) with "abcde" on the bottom line.
    for (int i = 0; i < 28; i++) send(8'h0A);
    check_cursor("lf_cursor", 29, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
    check_cursor("bottom_cursor", 29, 5);

    // Newline on the bottom line scrolls.
    send(8'h0A);
    check("scroll_ready_low", {31'b0, oReady}, 32'd0);
    wait_ready(c);
    check("scroll_clear_cycles", 32'(c), 32'd80);
    check_cursor("scroll_cursor", 29, 0);
    check_cell("scroll_l28_c0", 28, 0, 8'h61);
    check_cell("scroll_l28_c4", 28, 4, 8'h65);
    check_cell("scroll_l28_c5", 28, 5, 8'h20);
    check_cell("scroll_l0_c0", 0, 0, 8'h41);
    check_cell("scroll_l0_c1", 0, 1, 8'h20);
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      read_cell(29, k, v);
      if (v !== 8'h20) bad++;
    end
    check("scroll_l29_bad_cells", 32'(bad), 32'd0);

    // Wrap-scroll: the 80th byte lands on the old bottom row before it moves up.
    for (int i = 0; i < 80; i++) send(8'h5A);
    check("wscroll_ready_low", {31'b0, oReady}, 32'd0);
    wait_ready(c);
    check("wscroll_clear_cycles", 32'(c), 32'd80);
    check_cursor("wscroll_cursor", 29, 0);
    check_cell("wscroll_l28_c79", 28, 79, 8'h5A);
    check_cell("wscroll_l28_c0", 28, 0, 8'h5A);
    check_cell("wscroll_l27_c0", 27, 0, 8'h61);
    check_cell("wscroll_l29_c79", 29, 79, 8'h20);

    // Form feed clears everything and homes the cursor.
    send(8'h0C);
    check("ff_ready_low", {31'b0, oReady}, 32'd0);
    wait_ready(c);
    check("ff_clear_cycles", 32'(c), 32'd2400);
    check_cursor("ff_cursor", 0, 0);
    check_cell("ff_l27_c0", 27, 0, 8'h20);
    check_cell("ff_l28_c79", 28, 79, 8'h20);

    // Reset in the middle of a line clear.
    for (int i = 0; i < 29; i++) send(8'h0A);
    check_cursor("pre_scroll_cursor", 29, 0);
    send(8'h0A);
    repeat (10) @(posedge iClk_50);
    #1;
    check("midscroll_busy", {31'b0, oReady}, 32'd0);
    @(negedge iClk_50);
    Rst = 1'b1;
    @(posedge iClk_50); #1;
    check_cursor("midrst_cursor", 0, 0);
    check("midrst_top", {27'b0, dut.top}, 32'd0);
    check("midrst_clr_cnt", {20'b0, dut.clr_cnt}, 32'd0);
    check("midrst_ready", {31'b0, oReady}, 32'd0);
    @(negedge iClk_50);
    Rst = 1'b0;
    wait_ready(c);
    check("midrst_clear_cycles", 32'(c), 32'd2400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_console.md
# text_console

Character-cell text buffer and console writer that sits directly upstream of the font ROM in the display path. It accepts a byte stream over a valid/ready handshake and keeps an 80×30 screen of character codes with cursor, wrap, scroll and clear. Each cycle it converts the VGA controller's pixel row/column into the character code for that cell, and that code drives the font ROM's `iChar`.

## Interface
- `COLS`, 80: character columns; cells are 8 px wide.
- `ROWS`, 30: character rows; cells are 16 px tall.
- `iClk_50`  in  1: system clock; the only clock.
- `Rst`  in  1: synchronous, active-high reset.
- `iChar`  in  8: byte to print.
- `iValid`  in  1: `iChar` is valid.
- `oReady`  out  1: the block can accept a byte this cycle.
- `iRow`  in  10: pixel row from the VGA controller.
- `iCol`  in  10: pixel column from the VGA controller.
- `oChar`  out  8: character code for the cell at the registered `iRow`/`iCol`.
- `oCurRow`  out  5: cursor row, logical (0 is the top line on screen).
- `oCurCol`  out  7: cursor column.

## Operation
- Storage is COLS×ROWS bytes arranged as a circular buffer of rows. Register `top` (0..ROWS-1) is the physical row shown on screen line 0.
- **Handshake:** a byte transfers when `iValid && oReady` at a rising edge. `oReady` is 1 only in state IDLE.
- **States:**
  - IDLE: accepts bytes.
  - CLR_LINE: writes 0x20 to COLS cells.
  - CLR_ALL: writes 0x20 to COLS×ROWS cells, then sets `top`=0 and cursor=(0,0).
- **Byte decode in IDLE:**
  - 0x20–0x7E: write the byte at (cursor, `top`-adjusted row); then col+1.
  - When col would reach COLS: col=0 and perform a newline.
  - 0x0A (newline): col=0; if row<ROWS-1 then row+1, otherwise scroll.
  - 0x0D: col=0.
  - 0x08: if col>0 then col-1; no erase.
  - 0x0C: go to CLR_ALL.
  - All other bytes: accepted and ignored.
- **Scroll:** `top` = (`top`+1) mod ROWS; row stays at ROWS-1; go to CLR_LINE targeting the physical row equal to the old `top`.
- **Read path:**
  - Screen line = `iRow`[9:4]; cell column = `iCol`[9:3].
  - Physical row = (line + `top`) mod ROWS, computed by compare-and-subtract, with no divider.
  - If `iRow` ≥ ROWS·16 or `iCol` ≥ COLS·8, `oChar` = 0x00.
- **Arithmetic:** all modulo operations are single conditional subtracts. Address = physRow·COLS + col, 12 bits.

## Timing
- **Reset values:**
  - `oReady`=0, `oChar`=0x00, `oCurRow`=0, `oCurCol`=0, `top`=0.
  - State is CLR_ALL; a reset asserted mid-operation, in any state, restarts CLR_ALL from cell 0.
- **Read latency:** `oChar` at edge N+1 reflects `iRow`/`iCol` sampled at edge N; exactly 1 cycle.
- **Write timing:** a byte accepted at edge N is written to RAM at edge N. Cursor outputs update at edge N.
- **Read/write collision:** a read and write to the same cell in the same cycle returns the old data (read-before-write).
- **CLR_LINE:**
  - Lasts COLS cycles (80).
  - `oReady` falls at the edge that accepts the scrolling byte and rises COLS edges later.
  - The printable byte that caused a wrap-scroll is written before the line is cleared, on the old bottom row.
- **CLR_ALL:** lasts COLS×ROWS cycles (2400). After reset, `oReady` first goes high at edge 2400 after `Rst` is released.
- **Reads during clears:** the read path never stalls, so the display may show partially cleared rows.
- **Simultaneous events:** `iValid` while `oReady`=0 is ignored (not latched). The upstream holds `iChar` until the transfer.

## Structure
- Shared package/include `text_pkg`:
  - constants: COLS, ROWS, CHAR_W=8, CHAR_H=16, the clear byte 0x20, and the control codes 0x08/0x0A/0x0D/0x0C;
  - state encoding IDLE/CLR_LINE/CLR_ALL.
- One sub-module, `text_ram`: simple dual-port RAM, 2400×8, with one write port and one registered read port; read-before-write. Inferable as block RAM.
- The FSM, cursor, `top` register and address arithmetic live in `text_console`.

## Test plan
- **Reset:** release `Rst` → `oReady`=0 for 2400 cycles, then 1. Every on-screen cell reads 0x20. `iRow`=480, `iCol`=0 → `oChar`=0x00.
- **Print and read back:** send "Hi" (0x48, 0x69) → cursor (0,2). `iRow`=0, `iCol`=8 → `oChar`=0x69 one cycle later.
- **Line wrap:** send 81 bytes of 0x41 → cursor (1,1). Cell (1,0) = 0x41.
- **Scroll:** with cursor at (29,5), send 0x0A →
  - `oReady` low 80 cycles;
  - `top`=1, cursor (29,0);
  - screen line 28 shows the previous line 29;
  - line 29 is all 0x20.
- **Controls:** at col 3, send 0x08 → col 2; send 0x0D → col 0; send 0x07 → no change. Then send 0x0C → `oReady` low 2400 cycles, cursor (0,0).
- **Reset mid-scroll:** assert `Rst` during CLR_LINE → cursor (0,0), `top`=0, CLR_ALL restarts at cell 0.
